// File: rtl/shift_arbiter.sv
// Two-port arbiter sharing one combinational barrel shifter, with a registered
// one-entry response buffer that carries the requester id and tag.

module barrel_shifter (
    input  logic [31:0] data,
    input  logic [31:0] amt,
    input  logic [3:0]  sel,
    output logic [31:0] result
);
    // NOTE: assigning a default before the case keeps this block free of inferred latches.
    always_comb begin
        result = '0;
        if (amt < 32'd32) begin
            unique case (sel)
                4'd2:    result = data << amt[4:0];
                4'd6:    result = data >> amt[4:0];
                4'd7:    result = $signed(data) >>> amt[4:0];
                default: result = '0;
            endcase
        end
    end
endmodule

module shift_arbiter #(
    parameter int TAG_W        = 4,
    parameter bit PRIO_A       = 1'b0,
    parameter int STARVE_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [31:0]      a_rs1,
    input  logic [31:0]      a_rs2,
    input  logic [3:0]       a_sel,
    input  logic [TAG_W-1:0] a_tag,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [31:0]      b_rs1,
    input  logic [31:0]      b_rs2,
    input  logic [3:0]       b_sel,
    input  logic [TAG_W-1:0] b_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_result,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err
);
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

    localparam int             CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    port_e            last_grant;
    port_e            grant;
    logic [CNT_W-1:0] starve_cnt;
    logic             can_accept;
    logic             handshake;
    logic             legal;
    logic [31:0]      mux_rs1;
    logic [4:0]       mux_amt;
    logic [3:0]       mux_sel;
    logic [TAG_W-1:0] mux_tag;
    logic [31:0]      shift_out;
    logic             unused_rs2_hi;

    // Only the low five bits of a shift amount are meaningful.
    assign unused_rs2_hi = ^{a_rs2[31:5], b_rs2[31:5]};

    always_comb begin
        grant = PORT_A;
        if (a_valid && b_valid) begin
            if (PRIO_A)
                grant = (starve_cnt == CNT_MAX) ? PORT_B : PORT_A;
            else
                grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (b_valid) begin
            grant = PORT_B;
        end
    end

    assign can_accept = !resp_valid || resp_ready;
    assign handshake  = can_accept && (a_valid || b_valid);
    assign a_ready    = can_accept && a_valid && (grant == PORT_A);
    assign b_ready    = can_accept && b_valid && (grant == PORT_B);

    assign mux_rs1 = (grant == PORT_B) ? b_rs1      : a_rs1;
    assign mux_amt = (grant == PORT_B) ? b_rs2[4:0] : a_rs2[4:0];
    assign mux_sel = (grant == PORT_B) ? b_sel      : a_sel;
    assign mux_tag = (grant == PORT_B) ? b_tag      : a_tag;
    assign legal   = (mux_sel == 4'd2) || (mux_sel == 4'd6) || (mux_sel == 4'd7);

    barrel_shifter u_shifter (
        .data   (mux_rs1),
        .amt    ({27'b0, mux_amt}),
        .sel    (mux_sel),
        .result (shift_out)
    );

    // Arbitration state is frozen while the response buffer is stalled.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_B;
            starve_cnt <= '0;
        end else if (can_accept) begin
            if (handshake)
                last_grant <= grant;
            if (handshake && (grant == PORT_A) && b_valid) begin
                if (starve_cnt != CNT_MAX)
                    starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // Payload is held after drain; only resp_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_id     <= 1'b0;
            resp_tag    <= '0;
            resp_err    <= 1'b0;
        end else if (handshake) begin
            resp_valid  <= 1'b1;
            resp_result <= legal ? shift_out : 32'd0;
            resp_id     <= (grant == PORT_B);
            resp_tag    <= mux_tag;
            resp_err    <= !legal;
        end else if (resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and randomized checks of shift_arbiter against a behavioural model;
// a second instance with fixed priority exercises the starvation guard.

module tb_shift_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_valid, a_ready, b_valid, b_ready;
    logic [31:0] a_rs1, a_rs2, b_rs1, b_rs2;
    logic [3:0]  a_sel, b_sel, a_tag, b_tag;
    logic        resp_valid, resp_ready, resp_id, resp_err;
    logic [31:0] resp_result;
    logic [3:0]  resp_tag;

    logic        s_a_valid, s_a_ready, s_b_valid, s_b_ready;
    logic        s_resp_valid, s_resp_ready, s_resp_id, s_resp_err;
    logic [31:0] s_resp_result;
    logic [3:0]  s_resp_tag;

    int checks   = 0;
    int failures = 0;

    // Reference state: the response buffer contents and who won last.
    logic        m_valid;
    logic [31:0] m_result;
    logic        m_id;
    logic [3:0]  m_tag;
    logic        m_err;
    logic        m_last;
    logic        a_taken, b_taken;

    always #5 clk = ~clk;

    shift_arbiter #(.TAG_W(4), .PRIO_A(1'b0), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_rs1(a_rs1), .a_rs2(a_rs2), .a_sel(a_sel), .a_tag(a_tag),
        .b_valid(b_valid), .b_ready(b_ready), .b_rs1(b_rs1), .b_rs2(b_rs2), .b_sel(b_sel), .b_tag(b_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_id(resp_id), .resp_tag(resp_tag), .resp_err(resp_err)
    );

    shift_arbiter #(.TAG_W(4), .PRIO_A(1'b1), .STARVE_LIMIT(3)) dut_prio (
        .clk(clk), .rst_n(rst_n),
        .a_valid(s_a_valid), .a_ready(s_a_ready), .a_rs1(32'h1), .a_rs2(32'h1), .a_sel(4'd2), .a_tag(4'd1),
        .b_valid(s_b_valid), .b_ready(s_b_ready), .b_rs1(32'h2), .b_rs2(32'h1), .b_sel(4'd6), .b_tag(4'd2),
        .resp_valid(s_resp_valid), .resp_ready(s_resp_ready), .resp_result(s_resp_result),
        .resp_id(s_resp_id), .resp_tag(s_resp_tag), .resp_err(s_resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void ref_op(input logic [31:0] rs1, input logic [31:0] rs2, input logic [3:0] sel,
                                   output logic [31:0] res, output logic err);
        int amt;
        amt = int'(rs2 % 32);
        err = 1'b0;
        case (sel)
            4'd2:    res = rs1 << amt;
            4'd6:    res = rs1 >> amt;
            4'd7:    res = 32'($signed(rs1) >>> amt);
            default: begin res = 32'd0; err = 1'b1; end
        endcase
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0; m_result = '0; m_id = 1'b0; m_tag = '0; m_err = 1'b0;
        m_last = 1'b1;
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        logic can, wb, hs, rr;
        logic [31:0] rs1, rs2, res;
        logic [3:0]  sel, tag;
        logic        err;
        #1;
        rr  = resp_ready;
        can = !m_valid || rr;
        wb  = (a_valid && b_valid) ? !m_last : b_valid;
        hs  = can && (a_valid || b_valid);
        check("a_ready", a_ready, hs && !wb);
        check("b_ready", b_ready, hs && wb);
        a_taken = hs && !wb;
        b_taken = hs && wb;
        rs1 = wb ? b_rs1 : a_rs1;
        rs2 = wb ? b_rs2 : a_rs2;
        sel = wb ? b_sel : a_sel;
        tag = wb ? b_tag : a_tag;
        @(posedge clk);
        #1;
        if (hs) begin
            ref_op(rs1, rs2, sel, res, err);
            m_valid = 1'b1; m_result = res; m_err = err; m_id = wb; m_tag = tag; m_last = wb;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        check("resp_valid", resp_valid, m_valid);
        check("resp_result", resp_result, m_result);
        check("resp_id", resp_id, m_id);
        check("resp_tag", resp_tag, m_tag);
        check("resp_err", resp_err, m_err);
        @(negedge clk);
    endtask

    task automatic drive_a(input logic v, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [3:0] sel, input logic [3:0] tag);
        a_valid = v; a_rs1 = rs1; a_rs2 = rs2; a_sel = sel; a_tag = tag;
    endtask

    task automatic drive_b(input logic v, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [3:0] sel, input logic [3:0] tag);
        b_valid = v; b_rs1 = rs1; b_rs2 = rs2; b_sel = sel; b_tag = tag;
    endtask

    function automatic logic [3:0] rand_sel();
        int r;
        r = int'($urandom_range(0, 4));
        case (r)
            0:       return 4'd2;
            1:       return 4'd6;
            2:       return 4'd7;
            default: return 4'($urandom);
        endcase
    endfunction

    initial begin
        logic [3:0] rr_order;
        logic [7:0] prio_order;
        rr_order   = 4'b1010;
        prio_order = 8'b1000_1000;
        a_taken = 1'b0; b_taken = 1'b0;
        rst_n = 1'b0;
        drive_a(1'b0, '0, '0, '0, '0);
        drive_b(1'b0, '0, '0, '0, '0);
        resp_ready = 1'b1;
        s_a_valid = 1'b0; s_b_valid = 1'b0; s_resp_ready = 1'b1;
        model_reset();

        // Reset values
        #3;
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_resp_tag", resp_tag, 32'd0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_resp_id", resp_id, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic SLL
        drive_a(1'b1, 32'h0000_0001, 32'd31, 4'd2, 4'd5);
        cycle();
        check("sll_result", resp_result, 32'h8000_0000);
        check("sll_tag", resp_tag, 32'd5);
        drive_a(1'b0, '0, '0, '0, '0);

        // SRA / SRL with amount wrap on port B
        drive_b(1'b1, 32'h8000_0000, 32'h24, 4'd7, 4'd3);
        cycle();
        check("sra_result", resp_result, 32'hF800_0000);
        check("sra_id", resp_id, 1'b1);
        b_sel = 4'd6;
        cycle();
        check("srl_result", resp_result, 32'h0800_0000);

        // Round-robin: both valid, grants alternate with no bubbles
        drive_a(1'b1, 32'h0000_00F0, 32'd4, 4'd6, 4'd1);
        drive_b(1'b1, 32'h0000_000F, 32'd4, 4'd2, 4'd2);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_id", resp_id, rr_order[i]);
            check("rr_valid", resp_valid, 1'b1);
        end
        drive_b(1'b0, '0, '0, '0, '0);

        // Backpressure, then illegal op
        drive_a(1'b1, 32'h1234_5678, 32'd8, 4'd2, 4'd9);
        cycle();
        resp_ready = 1'b0;
        drive_a(1'b1, 32'hFFFF_FFFF, 32'd3, 4'd0, 4'd10);
        drive_b(1'b1, 32'hFFFF_FFFF, 32'd3, 4'd0, 4'd11);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_result", resp_result, 32'h3456_7800);
            check("bp_tag", resp_tag, 32'd9);
        end
        resp_ready = 1'b1;
        cycle();
        check("ill_result", resp_result, 32'd0);
        check("ill_err", resp_err, 1'b1);
        b_valid = 1'b0;
        cycle();
        check("ill_err_a", resp_err, 1'b1);
        a_valid = 1'b0;

        // Reset while a stalled response is pending
        drive_a(1'b1, 32'h0000_0003, 32'd1, 4'd2, 4'd4);
        resp_ready = 1'b0;
        cycle();
        a_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", resp_valid, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        drive_a(1'b1, 32'h0000_0001, 32'd1, 4'd2, 4'd6);
        drive_b(1'b1, 32'h0000_0001, 32'd1, 4'd2, 4'd7);
        cycle();
        check("post_rst_first_id", resp_id, 1'b0);

        // Randomized traffic; payloads held while a request waits
        for (int n = 0; n < 400; n++) begin
            if (!(a_valid && !a_taken))
                drive_a(1'($urandom_range(0, 1)), $urandom, $urandom, rand_sel(), 4'($urandom));
            if (!(b_valid && !b_taken))
                drive_b(1'($urandom_range(0, 1)), $urandom, $urandom, rand_sel(), 4'($urandom));
            resp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drive_a(1'b0, '0, '0, '0, '0);
        drive_b(1'b0, '0, '0, '0, '0);

        // Fixed priority with starvation guard
        s_a_valid = 1'b1;
        s_b_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("prio_valid", s_resp_valid, 1'b1);
            check("prio_id", s_resp_id, prio_order[i]);
        end
        s_a_valid = 1'b0;
        s_b_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
